// File: rtl/svm_inject_gen.sv
// svm_inject_gen: zero-sequence injection for N-phase PWM references.
// Min/max offset select, subtract, shift, symmetric clamp; 3-stage pipe.
package svm_pkg;
  typedef struct packed {
    logic clk;
    logic rstn;
  } clock_t;
endpackage

module svm_inject_gen
  import svm_pkg::*;
#(
  parameter int W   = 16,
  parameter int NCH = 3,
  parameter int OSH = 1
) (
  input  clock_t             clock,
  input  logic               in_val,
  input  logic [NCH*W-1:0]   in_data,
  input  logic [1:0]         mode,
  input  logic               sat_clr,
  output logic               out_val,
  output logic [NCH*W-1:0]   out_data,
  output logic [NCH-1:0]     sat_flag
);

  localparam int WE = W + 2;
  localparam logic signed [WE-1:0] LIM  = WE'(2**(W-1) - 1);
  localparam logic signed [WE-1:0] NLIM = -LIM;

  logic clk;
  logic rstn;
  assign clk  = clock.clk;
  assign rstn = clock.rstn;

  logic signed [W-1:0]  cmax, cmin;
  logic                 s1_v;
  logic [NCH*W-1:0]     s1_x;
  logic [1:0]           s1_mode;
  logic signed [W-1:0]  s1_max, s1_min;
  logic signed [WE-1:0] off;
  logic                 s2_v;
  logic [NCH*W-1:0]     s2_x;
  logic signed [WE-1:0] s2_off;
  logic signed [WE-1:0] dif [NCH];
  logic [NCH*W-1:0]     s3_d;
  logic [NCH-1:0]       s3_sat;

  // channel extremes of the incoming vector
  always_comb begin
    cmax = in_data[W-1:0];
    cmin = in_data[W-1:0];
    for (int i = 1; i < NCH; i++) begin
      if ($signed(in_data[i*W +: W]) > cmax)
        cmax = in_data[i*W +: W];
      if ($signed(in_data[i*W +: W]) < cmin)
        cmin = in_data[i*W +: W];
    end
  end

  // S1: capture sample, mode and extremes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v    <= 1'b0;
      s1_x    <= '0;
      s1_mode <= '0;
      s1_max  <= '0;
      s1_min  <= '0;
    end else begin
      s1_v <= in_val;
      if (in_val) begin
        s1_x    <= in_data;
        s1_mode <= mode;
        s1_max  <= cmax;
        s1_min  <= cmin;
      end
    end
  end

  // common-mode offset for the selected modulation
  always_comb begin
    off = '0;
    unique case (s1_mode)
      2'd0: off = '0;
      2'd1: off = (WE'(s1_max) + WE'(s1_min)) >>> 1;
      2'd2: off = WE'(s1_max) - LIM;
      2'd3: off = WE'(s1_min) + LIM;
    endcase
  end

  // S2: register offset alongside the sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v   <= 1'b0;
      s2_x   <= '0;
      s2_off <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_x   <= s1_x;
        s2_off <= off;
      end
    end
  end

  // subtract, scale and clamp to the symmetric range
  always_comb begin
    s3_d   = '0;
    s3_sat = '0;
    for (int i = 0; i < NCH; i++) begin
      dif[i] = (WE'($signed(s2_x[i*W +: W])) - s2_off) >>> OSH;
      if (dif[i] > LIM) begin
        s3_d[i*W +: W] = LIM[W-1:0];
        s3_sat[i]      = 1'b1;
      end else if (dif[i] < NLIM) begin
        s3_d[i*W +: W] = NLIM[W-1:0];
        s3_sat[i]      = 1'b1;
      end else begin
        s3_d[i*W +: W] = dif[i][W-1:0];
      end
    end
  end

  // S3: output registers; a new saturation beats a clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_val  <= 1'b0;
      out_data <= '0;
      sat_flag <= '0;
    end else begin
      out_val <= s2_v;
      if (s2_v)
        out_data <= s3_d;
      sat_flag <= (sat_clr ? '0 : sat_flag)
                | (s2_v ? s3_sat : '0);
    end
  end

endmodule

// File: tb/tb_svm_inject_gen.sv
// tb_svm_inject_gen: scoreboard bench, OSH=0 and OSH=1 instances
// driven in parallel against a behavioural model.
module tb_svm_inject_gen;
  import svm_pkg::*;

  typedef struct {
    int          cyc;
    logic [47:0] d0;
    logic [47:0] d1;
  } exp_t;

  logic        clk;
  logic        rstn;
  clock_t      ck;
  logic        in_val;
  logic [47:0] in_data;
  logic [1:0]  mode;
  logic        sat_clr;
  logic        ov0, ov1;
  logic [47:0] od0, od1;
  logic [2:0]  sf0, sf1;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  assign ck = {clk, rstn};

  svm_inject_gen #(.W(16), .NCH(3), .OSH(0)) u0 (
    .clock(ck), .in_val(in_val), .in_data(in_data),
    .mode(mode), .sat_clr(sat_clr), .out_val(ov0),
    .out_data(od0), .sat_flag(sf0)
  );

  svm_inject_gen #(.W(16), .NCH(3), .OSH(1)) u1 (
    .clock(ck), .in_val(in_val), .in_data(in_data),
    .mode(mode), .sat_clr(sat_clr), .out_val(ov1),
    .out_data(od1), .sat_flag(sf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [47:0] pk(input int a, input int b, input int c);
    logic [15:0] x0, x1, x2;
    x0 = 16'(a);
    x1 = 16'(b);
    x2 = 16'(c);
    return {x2, x1, x0};
  endfunction

  function automatic logic [47:0] model(input logic [47:0] x,
                                        input logic [1:0] m,
                                        input int osh);
    int v[3];
    int mx, mn, off, d;
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] s;
      s = x[i*16 +: 16];
      v[i] = int'($signed(s));
    end
    mx = v[0];
    mn = v[0];
    for (int i = 1; i < 3; i++) begin
      if (v[i] > mx) mx = v[i];
      if (v[i] < mn) mn = v[i];
    end
    case (m)
      2'd0: off = 0;
      2'd1: off = (mx + mn) >>> 1;
      2'd2: off = mx - 32767;
      default: off = mn + 32767;
    endcase
    for (int i = 0; i < 3; i++) begin
      d = (v[i] - off) >>> osh;
      if (d > 32767) d = 32767;
      if (d < -32767) d = -32767;
      r[i*16 +: 16] = d[15:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [47:0] o,
                     input logic [47:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (ov0 || ov1) begin
      if (sb.size() == 0) begin
        chk("stray_val", {46'd0, ov1, ov0}, 48'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 48'(cyc), 48'(e.cyc));
        chk("val0", {47'd0, ov0}, 48'd1);
        chk("val1", {47'd0, ov1}, 48'd1);
        chk("data_osh0", od0, e.d0);
        chk("data_osh1", od1, e.d1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    in_val = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_k(input logic [47:0] x, input logic [1:0] m,
                        input logic [47:0] e0, input logic [47:0] e1);
    exp_t e;
    in_val  = 1'b1;
    in_data = x;
    mode    = m;
    e.cyc   = cyc + 3;
    e.d0    = e0;
    e.d1    = e1;
    sb.push_back(e);
    tick();
  endtask

  task automatic send(input logic [47:0] x, input logic [1:0] m);
    send_k(x, m, model(x, m, 0), model(x, m, 1));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rstn    = 1'b1;
    in_val  = 1'b0;
    in_data = '0;
    mode    = '0;
    sat_clr = 1'b0;
    #1 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_val", {46'd0, ov1, ov0}, 48'd0);
    chk("rst_data0", od0, 48'd0);
    chk("rst_data1", od1, 48'd0);
    chk("rst_sat", {42'd0, sf1, sf0}, 48'd0);
    rstn = 1'b1;
    idle(2);

    send_k(pk(1000, -200, -800), 2'd1,
           pk(900, -300, -900), pk(450, -150, -450));
    idle(5);
    chk("hold_data1", od1, pk(450, -150, -450));

    send_k(pk(3, 0, -2), 2'd1, pk(3, 0, -2), pk(1, 0, -1));
    send_k(pk(-3, 0, 2), 2'd1, pk(-2, 1, 3), pk(-1, 0, 1));
    send_k(pk(-32768, 0, 100), 2'd3,
           pk(-32767, 1, 101), pk(-16384, 0, 50));
    send_k(pk(1000, -200, -800), 2'd2,
           pk(32767, 31567, 30967), pk(16383, 15783, 15483));
    send(pk(1000, -200, -800), 2'd0);
    send(pk(1000, -200, -800), 2'd1);
    idle(4);
    chk("nosat0", {45'd0, sf0}, 48'd0);

    send_k(pk(-32768, 0, 100), 2'd0,
           pk(-32767, 0, 100), pk(-16384, 0, 50));
    idle(4);
    chk("sat0_set", {45'd0, sf0}, 48'd1);
    chk("sat1_none", {45'd0, sf1}, 48'd0);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat0_clr", {45'd0, sf0}, 48'd0);
    send_k(pk(-32768, 0, 100), 2'd0,
           pk(-32767, 0, 100), pk(-16384, 0, 50));
    idle(1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat0_setwins", {45'd0, sf0}, 48'd1);
    idle(3);

    for (int i = 0; i < 8; i++)
      send(pk(i * 4000 - 16000, 500 * i, -1000 * i), 2'(i));
    idle(4);

    for (int i = 0; i < 40; i++) begin
      logic [47:0] x;
      x = {$urandom, $urandom};
      if (i % 10 == 0) x = pk(32767, -32768, 0);
      send(x, 2'($urandom_range(0, 3)));
    end
    idle(4);

    send(pk(1234, -5678, 910), 2'd1);
    in_val = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_val", {46'd0, ov1, ov0}, 48'd0);
    chk("arst_data0", od0, 48'd0);
    chk("arst_sat", {42'd0, sf1, sf0}, 48'd0);
    sb.delete();
    tick();
    rstn = 1'b1;
    idle(5);
    send(pk(-1234, 5678, -910), 2'd2);
    idle(5);

    chk("drain", 48'(sb.size()), 48'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
